// File: rtl/wb_intercon_pkg.sv
// Shared constants and types for the Wishbone address-slot interconnect.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package wb_intercon_pkg;

  localparam int NUM_SLAVES = 16;
  localparam int DW         = 32;
  localparam int SEL_MSB    = 31;
  localparam int SEL_LSB    = 28;
  localparam int ERR_SLOT   = 16;
  localparam int NSTB       = NUM_SLAVES + 1;

  localparam logic [DW-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Slot map: 0 RAM, 1 disk, 2 VRAM, 3 keyboard, 4 counter, 5..15 free.
  typedef logic [SEL_MSB-SEL_LSB:0] slot_t;

  // The top address nibble picks the slave slot.
  function automatic slot_t addr_slot(input logic [DW-1:0] addr);
    return addr[SEL_MSB:SEL_LSB];
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Watchdog for unacknowledged strobes: counts waiting cycles and fires a bus error.
// Latency: err_o is combinational from the registered count; lock_o is registered.
// Backpressure: after an error, lock_o holds until the master drops its strobe.
module wb_watchdog
  import wb_intercon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_i,
  input  logic ack_i,
  output logic err_o,
  output logic lock_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic          hit;

  // A real slave ACK on the limit cycle wins over the error.
  assign hit    = (cnt_q == LIMIT);
  assign err_o  = stb_i & ~lock_q & ~ack_i & hit;
  assign lock_o = lock_q;

  // Next-state: clear on idle/ack/error, count while waiting, lock after an error.
  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (!stb_i) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (lock_q || ack_i || hit) begin
      // Every path out of "waiting" acknowledges the master, so the count restarts.
      cnt_d = '0;
      if (err_o) lock_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset aborts any pending wait and releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/wb_intercon.sv
// Single-master Wishbone interconnect: address-nibble decode to 16 slaves, optional watchdog.
// Latency: zero-cycle combinational decode/mux; watchdog (WB_INTERCON_TIMEOUT_EN) errors after TIMEOUT_CYCLES.
// Backpressure: master waits on the selected slave ACK; after a bus error strobes stay low until master_STB drops.
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 255,
  parameter logic [DW-1:0]   ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 master_STB,
  input  logic                 master_WE,
  input  logic [DW-1:0]        master_ADDR,
  input  logic [DW-1:0]        master_DAT_I,
  output logic [DW-1:0]        master_DAT_O,
  output logic                 master_ACK,
  output logic [NSTB-1:0]      slave_STB,
  input  logic [NSTB-1:0]      slave_ACK,
  output logic                 slave_WE,
  output logic [DW-1:0]        slave_ADDR,
  output logic [DW-1:0]        slave_DAT_O,
  input  logic [NUM_SLAVES*DW-1:0] slave_DAT_I,
  output logic                 bus_err
);

  slot_t         sel;
  logic [DW-1:0] lane;
  logic          sel_ack;
  logic          wd_err;
  logic          wd_lock;
  logic          unused_err_ack;

  assign sel         = addr_slot(master_ADDR);
  assign sel_ack     = slave_ACK[sel];
  assign slave_WE    = master_WE;
  assign slave_ADDR  = master_ADDR;
  assign slave_DAT_O = master_DAT_I;

  // The error slot has no real slave behind it, so its ACK is never looked at.
  assign unused_err_ack = slave_ACK[ERR_SLOT];

  // Read-data mux: pick the selected slave's lane.
  always_comb begin
    lane = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel == slot_t'(k)) lane = slave_DAT_I[k*DW +: DW];
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .stb_i  (master_STB),
    .ack_i  (sel_ack),
    .err_o  (wd_err),
    .lock_o (wd_lock)
  );
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_clk;

  assign unused_clk = clk;
  assign wd_err     = 1'b0;
  assign wd_lock    = 1'b0;
`endif

  // Strobe/ACK steering; reset gates all handshakes while data keeps passing through.
  always_comb begin
    slave_STB    = '0;
    master_ACK   = 1'b0;
    bus_err      = 1'b0;
    master_DAT_O = wd_err ? ERR_DATA : lane;
    if (rst_n && master_STB && !wd_lock) begin
      if (wd_err) begin
        slave_STB[ERR_SLOT] = 1'b1;
        master_ACK          = 1'b1;
        bus_err             = 1'b1;
      end else begin
        slave_STB[sel] = 1'b1;
        master_ACK     = sel_ack;
      end
    end
  end

endmodule

// File: tb/tb_wb_intercon.sv
// Self-checking bench for wb_intercon: directed transfers scored through an expectation queue.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_wb_intercon;

  localparam int          TO   = 255;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         master_STB;
  logic         master_WE;
  logic [31:0]  master_ADDR;
  logic [31:0]  master_DAT_I;
  logic [31:0]  master_DAT_O;
  logic         master_ACK;
  logic [16:0]  slave_STB;
  logic [16:0]  slave_ACK;
  logic         slave_WE;
  logic [31:0]  slave_ADDR;
  logic [31:0]  slave_DAT_O;
  logic [511:0] slave_DAT_I;
  logic         bus_err;

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t sb_q[$];

  wb_intercon dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .master_STB   (master_STB),
    .master_WE    (master_WE),
    .master_ADDR  (master_ADDR),
    .master_DAT_I (master_DAT_I),
    .master_DAT_O (master_DAT_O),
    .master_ACK   (master_ACK),
    .slave_STB    (slave_STB),
    .slave_ACK    (slave_ACK),
    .slave_WE     (slave_WE),
    .slave_ADDR   (slave_ADDR),
    .slave_DAT_O  (slave_DAT_O),
    .slave_DAT_I  (slave_DAT_I),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit reached: got still running, want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_exp(input int k);
    logic [31:0] v;
    v = (k == 4) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(k));
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] dat, input logic err, input int cyc);
    exp_t e;
    e.dat = dat;
    e.err = err;
    e.cyc = 16'(cyc);
    return e;
  endfunction

  // Starts a strobe (called 1ns after posedge), raises the slot ACK ack_dly cycles in
  // (never if negative), and scores the master-side ACK against the queued expectation.
  // Returns on the negedge where master_ACK was seen, strobe still held.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdat, input int ack_dly, input exp_t e);
    exp_t got;
    int   s;
    bit   done;
    s            = int'(addr[31:28]);
    master_ADDR  = addr;
    master_WE    = we;
    master_DAT_I = wdat;
    slave_ACK    = '0;
    master_STB   = 1'b1;
    sb_q.push_back(e);
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (ack_dly >= 0 && n >= ack_dly) slave_ACK[s] = 1'b1;
      @(negedge clk);
      if (n == 0) begin
        check({tag, "_stb"},   64'(slave_STB),   64'(17'd1 << s));
        check({tag, "_addr"},  64'(slave_ADDR),  64'(addr));
        check({tag, "_we"},    64'(slave_WE),    64'(we));
        check({tag, "_wdat"},  64'(slave_DAT_O), 64'(wdat));
      end
      if (master_ACK) begin
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check({tag, "_rdat"},   64'(master_DAT_O), 64'(got.dat));
          check({tag, "_buserr"}, 64'(bus_err),      64'(got.err));
          check({tag, "_stb16"},  64'(slave_STB[16]), 64'(got.err));
          check({tag, "_cycles"}, 64'(n),            64'(got.cyc));
        end
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      check({tag, "_ack_seen"}, 64'd0, 64'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  // Drop the strobe after a transfer and confirm the ACK goes away.
  task automatic idle(input string tag);
    @(posedge clk);
    #1;
    master_STB = 1'b0;
    master_WE  = 1'b0;
    slave_ACK  = '0;
    @(negedge clk);
    check({tag, "_ack_low"}, 64'(master_ACK), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int viol;
    for (int k = 0; k < 16; k++) slave_DAT_I[k*32 +: 32] = lane_exp(k);
    rst_n        = 1'b0;
    master_STB   = 1'b1;
    master_WE    = 1'b0;
    master_ADDR  = 32'h4000_0000;
    master_DAT_I = 32'h0;
    slave_ACK    = '1;

    // Reset state: handshakes forced low, datapath still passes.
    @(negedge clk);
    check("rst_stb",   64'(slave_STB),    64'd0);
    check("rst_ack",   64'(master_ACK),   64'd0);
    check("rst_err",   64'(bus_err),      64'd0);
    check("rst_addr",  64'(slave_ADDR),   64'h4000_0000);
    check("rst_rdat",  64'(master_DAT_O), 64'(lane_exp(4)));
    @(posedge clk);
    #1;
    master_STB = 1'b0;
    slave_ACK  = '0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;

    // Read slot 4, ACK after 2 cycles.
    xfer("rd4", 32'h4000_0000, 1'b0, 32'h0, 2, mk_exp(32'h1234_5678, 1'b0, 2));
    check("rd4_stbmask", 64'(slave_STB), 64'h00010);
    idle("rd4");

    // Write slot 0, ACK already high: single-cycle transfer.
    xfer("wr0", 32'h0000_0010, 1'b1, 32'hCAFE_F00D, 0, mk_exp(lane_exp(0), 1'b0, 0));
    idle("wr0");

    // Every slot, ACK one cycle in.
    for (int k = 0; k < 16; k++) begin
      xfer($sformatf("slot%0d", k), {4'(k), 28'h0000_ABC}, 1'b0, 32'h0, 1,
           mk_exp(lane_exp(k), 1'b0, 1));
      idle($sformatf("slot%0d", k));
    end

    // Stray ACK from a non-selected slave.
    master_ADDR = 32'h2000_0004;
    master_STB  = 1'b1;
    slave_ACK   = 17'h00008;
    viol = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (master_ACK) viol++;
      @(posedge clk);
      #1;
    end
    check("stray_ack_count", 64'(viol), 64'd0);
    check("stray_stb", 64'(slave_STB), 64'h00004);
    master_STB = 1'b0;
    slave_ACK  = '1;
    @(negedge clk);
    check("nostb_ack", 64'(master_ACK), 64'd0);
    check("nostb_stb", 64'(slave_STB),  64'd0);
    @(posedge clk);
    #1;
    slave_ACK = '0;

    // Real ACK landing on the watchdog limit cycle is honoured.
    xfer("late6", 32'h6000_0000, 1'b0, 32'h0, TO, mk_exp(lane_exp(6), 1'b0, TO));
    idle("late6");

    // Reset gating with a held strobe and a high ACK, then recovery.
    master_ADDR = 32'h3000_0000;
    master_STB  = 1'b1;
    slave_ACK   = 17'h00008;
    @(negedge clk);
    check("pre_rst_ack", 64'(master_ACK), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ack", 64'(master_ACK), 64'd0);
    check("mid_rst_stb", 64'(slave_STB),  64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack",  64'(master_ACK),   64'd1);
    check("post_rst_rdat", 64'(master_DAT_O), 64'(lane_exp(3)));
    idle("rst3");

`ifdef WB_INTERCON_TIMEOUT_EN
    // Timeout on slot 7, then the post-error lock while the strobe is held.
    xfer("to7", 32'h7000_0000, 1'b0, 32'h0, -1, mk_exp(ERRD, 1'b1, TO));
    check("to7_stbmask", 64'(slave_STB), 64'h10000);
    viol = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (n == 150) slave_ACK[7] = 1'b1;
      @(negedge clk);
      if (slave_STB != 17'd0 || master_ACK || bus_err) viol++;
    end
    check("lock_quiet", 64'(viol), 64'd0);
    idle("to7");
    xfer("fresh1", 32'h1000_0000, 1'b0, 32'h0, 0, mk_exp(lane_exp(1), 1'b0, 0));
    idle("fresh1");

    // Reset at cycle 100 of a pending access; count restarts after release.
    master_ADDR = 32'h5000_0000;
    master_STB  = 1'b1;
    slave_ACK   = '0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("wait_rst_stb", 64'(slave_STB), 64'd0);
    check("wait_rst_err", 64'(bus_err),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer("rst5", 32'h5000_0000, 1'b0, 32'h0, -1, mk_exp(ERRD, 1'b1, TO));
    idle("rst5");
`else
    // Without the watchdog, a missing ACK simply stalls.
    master_ADDR = 32'h9000_0000;
    master_STB  = 1'b1;
    slave_ACK   = '0;
    viol = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (master_ACK || bus_err || slave_STB[16]) viol++;
      @(posedge clk);
      #1;
    end
    check("noto_quiet", 64'(viol), 64'd0);
    @(negedge clk);
    check("noto_stb", 64'(slave_STB), 64'h00200);
    idle("noto");
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule

// File: doc/wb_intercon.md
WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
- Parameter TIMEOUT_CYCLES, default 255: cycles an unacknowledged strobe may wait before a bus error.
- Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on a bus error.
REQ-002 SHALL have the following ports:
- clk  in  1  bus clock.
- rst_n  in  1  asynchronous reset, active low.
- master_STB  in  1  master strobe.
- master_WE  in  1  master write enable.
- master_ADDR  in  32  master byte address.
- master_DAT_I  in  32  write data from the master.
- master_DAT_O  out  32  read data to the master.
- master_ACK  out  1  acknowledge to the master.
- slave_STB  out  17  per-slave strobes; bit 16 is the bus-error pulse.
- slave_ACK  in  17  per-slave acknowledges; bit 16 is ignored.
- slave_WE  out  1  write enable broadcast to all slaves.
- slave_ADDR  out  32  address broadcast to all slaves.
- slave_DAT_O  out  32  write data broadcast to all slaves.
- slave_DAT_I  in  512  read data from slaves; lane k is bits [32k+31:32k].
- bus_err  out  1  one-cycle bus-error pulse.

Function
REQ-003 SHALL compute the slot as sel = master_ADDR[31:28], giving slot 0..15 (slot 0 RAM, 1 disk, 2 VRAM, 3 keyboard, 4 counter, 5..15 free).
REQ-004 SHALL drive slave_STB[sel] = master_STB combinationally and hold every other slave_STB bit at 0.
REQ-005 SHALL pass master_ADDR to slave_ADDR, master_WE to slave_WE and master_DAT_I to slave_DAT_O unmodified, with zero latency.
REQ-006 SHALL drive master_DAT_O = slave_DAT_I lane sel, and master_ACK = master_STB & slave_ACK[sel], both combinationally.
REQ-007 SHALL ignore ACKs from non-selected slaves.
REQ-008 SHALL keep master_ACK at 0 whenever master_STB is 0, even if a slave ACK is high.
REQ-009 SHALL run a watchdog counter with these rules:
- Clear to 0 when master_STB=0 or master_ACK=1.
- Otherwise increment by 1 each clk, saturating at TIMEOUT_CYCLES.
REQ-010 SHALL raise a bus error on the cycle the counter equals TIMEOUT_CYCLES, and on that cycle:
- master_ACK=1, master_DAT_O=ERR_DATA;
- slave_STB[15:0]=0, slave_STB[16]=1, bus_err=1.
REQ-011 SHALL, after a bus error, keep slave_STB[15:0], master_ACK and bus_err at 0 until master_STB returns to 0; the next strobe then starts a fresh transaction.
REQ-012 SHALL, when a real slave ACK and the timeout fall on the same cycle, honour the real ACK: deliver slave data, raise no error.
REQ-013 SHALL produce a single-cycle transaction when the slave ACK is already high on the first strobe cycle.

Reset
REQ-014 SHALL, while rst_n=0, clear the counter and the post-error lock and force slave_STB=0, master_ACK=0 and bus_err=0 (datapath pass-through continues).
REQ-015 SHALL, if reset is asserted mid-transaction, abort the transaction; once rst_n=1, a held master_STB restarts decode and the count from 0.

Configuration
REQ-016 SHALL include the watchdog logic (REQ-009..012) only when macro WB_INTERCON_TIMEOUT_EN is defined.
REQ-017 SHALL, without WB_INTERCON_TIMEOUT_EN:
- be purely combinational per REQ-003..008, waiting indefinitely for a slave ACK;
- tie slave_STB[16] and bus_err to 0;
- leave clk and rst_n unused except for REQ-014 gating.

Structure
REQ-018 SHALL place the following constants in shared package wb_intercon_pkg:
- NUM_SLAVES=16, DW=32, SEL_MSB=31, SEL_LSB=28;
- ERR_SLOT=16, default ERR_DATA.
REQ-019 SHALL implement the counter and post-error lock in one sub-module, wb_watchdog, with decode and muxing kept in the top level.

Verification
REQ-020 SHALL cover the following directed scenarios:
- Read slot 4, ADDR=0x4000_0000, lane4=0x1234_5678, ACK[4] high after 2 cycles -> slave_STB=0x00010, master_DAT_O=0x1234_5678, master_ACK high 1 cycle.
- Write ADDR=0x0000_0010, DAT_I=0xCAFE_F00D, WE=1 -> slave_STB[0]=1, slave_DAT_O=0xCAFE_F00D, slave_WE=1, ACK on slave_ACK[0] only.
- Stray ACK: slot 2 selected, ACK[3]=1 only -> master_ACK stays 0.
- Timeout: strobe slot 7, no ACK -> bus_err, slave_STB[16] and master_ACK high exactly TIMEOUT_CYCLES cycles after strobe; master_DAT_O=0xDEAD_BEEF; no further strobe until master_STB falls.
- Reset mid-wait: rst_n low at cycle 100 of a pending access -> all strobes 0 immediately; count restarts at 0 after release.
- Macro off: no ACK for 1000 cycles -> master_ACK never asserts, bus_err stays 0.
